// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - FSM-sequenced integer datapath with handshaked instruction/data memories.
// One instruction at a time: FETCH, DECODE, EXEC, optional MEM, WB; illegal opcodes park the core in HALT.
module multicycle_datapath #(
   parameter int DATA_WIDTH = 16,
   parameter int REG_NUM    = 16,
   parameter int PC_WIDTH   = 16,
   parameter int LINK_REG   = 7
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  lock,
   output logic                  imem_req,
   output logic [PC_WIDTH-3:0]   imem_addr,
   input  logic                  imem_ready,
   input  logic [31:0]           imem_rdata,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [DATA_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic                  dmem_ready,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic [PC_WIDTH-1:0]   pc_out,
   output logic [2:0]            cc_out,
   output logic                  retire,
   output logic                  halted
);

   localparam logic [4:0] OP_BR   = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00001;
   localparam logic [4:0] OP_JSRR = 5'b00010;
   localparam logic [4:0] OP_MOV  = 5'b00011;
   localparam logic [4:0] OP_JSR  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_LDW  = 5'b00110;
   localparam logic [4:0] OP_STW  = 5'b00111;
   localparam logic [4:0] OP_JMP  = 5'b01100;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t state, state_next;

   logic [PC_WIDTH-1:0]   pc;
   logic [31:0]           ir;
   logic [2:0]            cc;
   logic [DATA_WIDTH-1:0] regs [REG_NUM];
   logic [DATA_WIDTH-1:0] op_a, op_b, op_d;
   logic [DATA_WIDTH-1:0] result;
   logic [DATA_WIDTH-1:0] mem_addr;

   logic [4:0]            opcode;
   logic                  imm_sel;
   logic [2:0]            nzp;
   logic [3:0]            dst, src1, src2;
   logic signed [15:0]    imm16;

   logic [DATA_WIDTH-1:0] imm_ext, opnd_b, alu, agu;
   logic                  is_legal, is_mem, is_stw, active;

   logic [PC_WIDTH-1:0]   pc_inc, pc_rel, pc_next;
   logic                  br_taken;
   logic                  wr_en, cc_wr;
   logic [3:0]            wr_idx;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [2:0]            cc_next;

   assign opcode  = ir[31:27];
   assign imm_sel = ir[24];
   assign nzp     = ir[26:24];
   assign dst     = ir[23:20];
   assign src1    = ir[19:16];
   assign src2    = ir[11:8];
   assign imm16   = signed'(ir[15:0]);

   assign is_legal = opcode inside {OP_BR, OP_ADD, OP_JSRR, OP_MOV, OP_JSR,
                                    OP_AND, OP_LDW, OP_STW, OP_JMP};
   assign is_mem   = (opcode == OP_LDW) || (opcode == OP_STW);
   assign is_stw   = (opcode == OP_STW);
   assign active   = reset_n && lock;

   // Register specifiers beyond REG_NUM read as zero and are never written.
   function automatic logic [DATA_WIDTH-1:0] reg_read(input logic [3:0] idx);
      reg_read = '0;
      for (int i = 0; i < REG_NUM; i++)
         if (idx == 4'(i)) reg_read = regs[i];
   endfunction

   always_comb begin
      imm_ext = DATA_WIDTH'(imm16);
      opnd_b  = imm_sel ? imm_ext : op_b;
      agu     = op_a + imm_ext;
      case (opcode)
         OP_ADD:  alu = op_a + opnd_b;
         OP_AND:  alu = op_a & opnd_b;
         OP_MOV:  alu = opnd_b;
         default: alu = '0;
      endcase
   end

   // nzp is {n,z,p} while cc is {P,Z,N}, so the bits pair up crosswise.
   always_comb begin
      pc_inc   = pc + PC_WIDTH'(4);
      pc_rel   = pc_inc + (PC_WIDTH'(imm16) << 2);
      br_taken = (nzp[2] & cc[0]) | (nzp[1] & cc[1]) | (nzp[0] & cc[2]);
      if (result[DATA_WIDTH-1])
         cc_next = 3'b001;
      else if (result == '0)
         cc_next = 3'b010;
      else
         cc_next = 3'b100;
   end

   always_comb begin
      pc_next = pc_inc;
      wr_en   = 1'b0;
      wr_idx  = dst;
      wr_data = result;
      cc_wr   = 1'b0;
      case (opcode)
         OP_ADD, OP_AND, OP_MOV, OP_LDW: begin
            wr_en = 1'b1;
            cc_wr = 1'b1;
         end
         OP_BR: begin
            if (br_taken) pc_next = pc_rel;
         end
         OP_JMP: pc_next = PC_WIDTH'(op_a);
         OP_JSR: begin
            wr_en   = 1'b1;
            wr_idx  = 4'(LINK_REG);
            wr_data = DATA_WIDTH'(pc_inc);
            pc_next = pc_rel;
         end
         // op_a was captured in DECODE, so src1 == LINK_REG still jumps to the old link.
         OP_JSRR: begin
            wr_en   = 1'b1;
            wr_idx  = 4'(LINK_REG);
            wr_data = DATA_WIDTH'(pc_inc);
            pc_next = PC_WIDTH'(op_a);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:  if (imem_ready) state_next = S_DECODE;
         S_DECODE: state_next = is_legal ? S_EXEC : S_HALT;
         S_EXEC:   state_next = is_mem ? S_MEM : S_WB;
         S_MEM:    if (dmem_ready) state_next = S_WB;
         S_WB:     state_next = S_FETCH;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= S_FETCH;
         pc       <= '0;
         ir       <= '0;
         cc       <= 3'b010;
         op_a     <= '0;
         op_b     <= '0;
         op_d     <= '0;
         result   <= '0;
         mem_addr <= '0;
         for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      end else if (lock) begin
         state <= state_next;
         case (state)
            S_FETCH: if (imem_ready) ir <= imem_rdata;
            S_DECODE: begin
               op_a <= reg_read(src1);
               op_b <= reg_read(src2);
               op_d <= reg_read(dst);
            end
            S_EXEC: begin
               result   <= alu;
               mem_addr <= agu;
            end
            S_MEM: if (dmem_ready && !is_stw) result <= dmem_rdata;
            S_WB: begin
               pc <= pc_next;
               if (cc_wr) cc <= cc_next;
               for (int i = 0; i < REG_NUM; i++)
                  if (wr_en && wr_idx == 4'(i)) regs[i] <= wr_data;
            end
            default: ;
         endcase
      end
   end

   // Requests drop combinationally with lock or reset so a frozen core never starts a transfer.
   assign imem_req   = active && (state == S_FETCH);
   assign dmem_req   = active && (state == S_MEM);
   assign dmem_we    = dmem_req && is_stw;
   assign imem_addr  = pc[PC_WIDTH-1:2];
   assign dmem_addr  = mem_addr;
   assign dmem_wdata = op_d;
   assign pc_out     = pc;
   assign cc_out     = cc;
   assign retire     = active && (state == S_WB);
   assign halted     = reset_n && (state == S_HALT);

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - scoreboard bench for multicycle_datapath.
module tb_multicycle_datapath;

   localparam logic [4:0] OP_BR   = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00001;
   localparam logic [4:0] OP_JSRR = 5'b00010;
   localparam logic [4:0] OP_MOV  = 5'b00011;
   localparam logic [4:0] OP_JSR  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_LDW  = 5'b00110;
   localparam logic [4:0] OP_STW  = 5'b00111;
   localparam logic [4:0] OP_JMP  = 5'b01100;
   localparam logic [2:0] CC_P = 3'b100, CC_Z = 3'b010, CC_N = 3'b001;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        lock = 1'b1;
   logic        imem_req;
   logic [13:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        dmem_req, dmem_we;
   logic [15:0] dmem_addr, dmem_wdata;
   logic        dmem_ready = 1'b0;
   logic [15:0] dmem_rdata = '0;
   logic [15:0] pc_out;
   logic [2:0]  cc_out;
   logic        retire, halted;

   multicycle_datapath dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .lock       (lock),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ready (dmem_ready),
      .dmem_rdata (dmem_rdata),
      .pc_out     (pc_out),
      .cc_out     (cc_out),
      .retire     (retire),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] npc;
      logic [2:0]  cc;
      int          mem;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        post_e;
   bit          post = 0;
   bit          run = 0;
   bit          mem_seen = 0;
   bit          lock_done = 0;
   int          cyc = 0;
   int          last_ret = 0;
   int          dcnt = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] prog [0:63];
   logic [15:0] dmem [0:255];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ri(input logic [4:0] op, input logic [3:0] d,
                                      input logic [3:0] s1, input logic [15:0] imm);
      ri = {op, 3'b001, d, s1, imm};
   endfunction

   function automatic logic [31:0] rr(input logic [4:0] op, input logic [3:0] d,
                                      input logic [3:0] s1, input logic [3:0] s2);
      rr = {op, 3'b000, d, s1, 4'h0, s2, 8'h00};
   endfunction

   function automatic logic [31:0] br(input logic [2:0] cond, input logic [15:0] off);
      br = {OP_BR, cond, 8'h00, off};
   endfunction

   function automatic logic [31:0] jr(input logic [4:0] op, input logic [3:0] s1);
      jr = {op, 3'b000, 4'h0, s1, 16'h0000};
   endfunction

   function automatic logic [31:0] mi(input logic [4:0] op, input logic [3:0] d,
                                      input logic [3:0] s1, input logic [15:0] off);
      mi = {op, 3'b000, d, s1, off};
   endfunction

   task automatic add(input logic [15:0] pc, input logic [31:0] ins, input logic [15:0] npc,
                      input logic [2:0] cc, input int mem, input logic [15:0] addr,
                      input logic [15:0] wdata, input int ncyc);
      exp_t e;
      prog[pc[7:2]] = ins;
      e.pc = pc; e.npc = npc; e.cc = cc; e.mem = mem;
      e.addr = addr; e.wdata = wdata; e.cyc = ncyc;
      sb.push_back(e);
   endtask

   // Memory responder and retire monitor: imem is zero-wait, dmem completes on the 4th request cycle.
   initial begin
      exp_t e;
      logic [15:0] fpc;
      wait (run);
      forever begin
         @(negedge clk);
         cyc++;
         imem_rdata = (int'(imem_addr) < 64) ? prog[imem_addr[5:0]] : 32'hF800_0000;
         if (post) begin
            check("next_pc", 32'(pc_out), 32'(post_e.npc));
            check("cc", 32'(cc_out), 32'(post_e.cc));
            post = 0;
         end
         if (retire) begin
            if (sb.size() == 0) check("retire_extra", 32'(1), 32'(0));
            else begin
               e = sb.pop_front();
               check("retire_pc", 32'(pc_out), 32'(e.pc));
               if (e.cyc != 0) check("latency", 32'(cyc - last_ret), 32'(e.cyc));
               if (e.mem != 0) check("mem_done", 32'(mem_seen), 32'(1));
               last_ret = cyc;
               mem_seen = 0;
               post_e = e;
               post = 1;
            end
         end
         if (dmem_req) begin
            check("no_overlap", 32'(imem_req), 32'(0));
            if (sb.size() == 0) check("dmem_extra", 32'(1), 32'(0));
            else begin
               e = sb[0];
               if (e.pc == 16'h0064 && dcnt == 1 && !lock_done) begin
                  lock_done = 1;
                  lock = 1'b0;
                  #1;
                  check("lock_dreq", 32'(dmem_req), 32'(0));
                  fpc = pc_out;
                  repeat (5) begin
                     @(negedge clk);
                     cyc++;
                     check("lock_dreq", 32'(dmem_req), 32'(0));
                     check("lock_pc", 32'(pc_out), 32'(fpc));
                     check("lock_retire", 32'(retire), 32'(0));
                  end
                  lock = 1'b1;
                  #1;
                  check("lock_resume", 32'(dmem_req), 32'(1));
               end else if (dcnt == 3) begin
                  check("dmem_we", 32'(dmem_we), 32'(e.mem == 1));
                  check("dmem_addr", 32'(dmem_addr), 32'(e.addr));
                  if (e.mem == 1) begin
                     check("dmem_wdata", 32'(dmem_wdata), 32'(e.wdata));
                     dmem[dmem_addr[7:0]] = dmem_wdata;
                  end else begin
                     dmem_rdata = dmem[dmem_addr[7:0]];
                  end
                  dmem_ready = 1'b1;
                  mem_seen = 1;
                  dcnt = 0;
               end else begin
                  check("dmem_hold", 32'(dmem_addr), 32'(e.addr));
                  dcnt++;
               end
            end
         end else begin
            dmem_ready = 1'b0;
         end
      end
   end

   initial begin
      int n;
      for (int i = 0; i < 64; i++) prog[i] = '0;
      for (int i = 0; i < 256; i++) dmem[i] = '0;

      add(16'h00, ri(OP_MOV, 1, 0, 16'd5),       16'h04, CC_P, 0, 0, 0, 4);
      add(16'h04, ri(OP_MOV, 2, 0, 16'hFFFD),    16'h08, CC_N, 0, 0, 0, 4);
      add(16'h08, rr(OP_ADD, 3, 1, 2),           16'h0C, CC_P, 0, 0, 0, 4);
      add(16'h0C, ri(OP_MOV, 4, 0, 16'h00FF),    16'h10, CC_P, 0, 0, 0, 4);
      add(16'h10, ri(OP_AND, 5, 4, 16'h0000),    16'h14, CC_Z, 0, 0, 0, 4);
      add(16'h14, mi(OP_STW, 3, 0, 16'h0012),    16'h18, CC_Z, 1, 16'h12, 16'h0002, 8);
      add(16'h18, ri(OP_MOV, 10, 0, 16'hFFFE),   16'h1C, CC_N, 0, 0, 0, 4);
      add(16'h1C, ri(OP_ADD, 10, 10, 16'd1),     16'h20, CC_N, 0, 0, 0, 4);
      add(16'h20, br(3'b100, 16'hFFFE),          16'h1C, CC_N, 0, 0, 0, 4);
      add(16'h1C, ri(OP_ADD, 10, 10, 16'd1),     16'h20, CC_Z, 0, 0, 0, 4);
      add(16'h20, br(3'b100, 16'hFFFE),          16'h24, CC_Z, 0, 0, 0, 4);
      add(16'h24, ri(OP_MOV, 11, 0, 16'hFFF9),   16'h28, CC_N, 0, 0, 0, 4);
      add(16'h28, br(3'b011, 16'hFFFE),          16'h2C, CC_N, 0, 0, 0, 4);
      add(16'h2C, ri(OP_MOV, 12, 0, 16'h0040),   16'h30, CC_P, 0, 0, 0, 4);
      add(16'h30, jr(OP_JMP, 12),                16'h40, CC_P, 0, 0, 0, 4);
      add(16'h40, mi(OP_JSR, 0, 0, 16'd4),       16'h54, CC_P, 0, 0, 0, 4);
      add(16'h54, jr(OP_JSRR, 7),                16'h44, CC_P, 0, 0, 0, 4);
      add(16'h44, mi(OP_STW, 7, 0, 16'h0013),    16'h48, CC_P, 1, 16'h13, 16'h0058, 8);
      add(16'h48, ri(OP_MOV, 13, 0, 16'h0060),   16'h4C, CC_P, 0, 0, 0, 4);
      add(16'h4C, jr(OP_JMP, 13),                16'h60, CC_P, 0, 0, 0, 4);
      add(16'h60, mi(OP_STW, 1, 0, 16'h0010),    16'h64, CC_P, 1, 16'h10, 16'h0005, 8);
      add(16'h64, mi(OP_LDW, 6, 0, 16'h0010),    16'h68, CC_P, 2, 16'h10, 16'h0000, 0);
      add(16'h68, mi(OP_STW, 6, 0, 16'h0014),    16'h6C, CC_P, 1, 16'h14, 16'h0005, 8);
      prog[27] = 32'hF800_0000;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pc", 32'(pc_out), 32'(0));
      check("rst_cc", 32'(cc_out), 32'(CC_Z));
      check("rst_imem_req", 32'(imem_req), 32'(0));
      check("rst_dmem_req", 32'(dmem_req), 32'(0));
      check("rst_dmem_we", 32'(dmem_we), 32'(0));
      check("rst_retire", 32'(retire), 32'(0));
      check("rst_halted", 32'(halted), 32'(0));

      reset_n = 1'b1;
      imem_ready = 1'b1;
      imem_rdata = prog[0];
      cyc = 1;
      run = 1;
      #1;
      check("first_fetch", 32'(imem_req), 32'(1));

      n = 0;
      while ((sb.size() != 0 || post) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(sb.size()), 32'(0));

      repeat (4) @(negedge clk);
      check("halted", 32'(halted), 32'(1));
      check("halt_pc", 32'(pc_out), 32'h6C);
      repeat (5) begin
         @(negedge clk);
         check("halt_no_fetch", 32'(imem_req), 32'(0));
      end

      reset_n = 1'b0;
      @(negedge clk);
      check("rst2_halted", 32'(halted), 32'(0));
      check("rst2_pc", 32'(pc_out), 32'(0));
      check("rst2_cc", 32'(cc_out), 32'(CC_Z));
      check("rst2_imem_req", 32'(imem_req), 32'(0));
      reset_n = 1'b1;
      #1;
      check("rst2_fetch", 32'(imem_req), 32'(1));
      check("rst2_addr", 32'(imem_addr), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised, FSM-sequenced successor to the single-cycle integer datapath.
- Executes ADD/AND/MOV/LDW/STW/BR/JMP/JSR/JSRR. Opcode encodings come from global_def.h.
- Instruction and data memories are external, reached through req/ready handshakes, so wait states and shared memories are supported.
- Adds exclusive one-hot CC, sign-correct arithmetic, illegal-opcode halt and retire/debug outputs.

Parameters:
- DATA_WIDTH, 16, width of integer registers, ALU and data-memory words.
- REG_NUM, 16, number of integer registers (4-bit specifier fields; at most 16).
- PC_WIDTH, 16, width of the byte-addressed PC.
- LINK_REG, 7, register written with the return address by JSR/JSRR.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- lock  in  1  run enable; low freezes the core.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_WIDTH-2  word address (PC>>2).
- imem_ready  in  1  fetch completes this cycle.
- imem_rdata  in  32  instruction word, valid when imem_req&&imem_ready.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1=store, 0=load.
- dmem_addr  out  DATA_WIDTH  data word address.
- dmem_wdata  out  DATA_WIDTH  store data.
- dmem_ready  in  1  access completes this cycle.
- dmem_rdata  in  DATA_WIDTH  load data, valid when dmem_req&&dmem_ready&&!dmem_we.
- pc_out  out  PC_WIDTH  current PC.
- cc_out  out  3  {P,Z,N}.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped on illegal opcode.

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - PC=0, all registers=0, CC=3'b010 (Z), state=FETCH.
  - imem_req=0, dmem_req=0, dmem_we=0, retire=0, halted=0.
  - Reset mid-handshake abandons the transfer.
- Instruction fields:
  - [31:27] opcode; [24] imm select for ADD/AND/MOV; [26:24] nzp for BR.
  - [23:20] dst (STW: source data); [19:16] src1; [11:8] src2; [15:0] imm16.
  - imm16 is sign-extended/truncated to DATA_WIDTH.
- lock=0: no state change and no PC/reg/CC/memory update; imem_req and dmem_req forced 0. Resumes exactly where it stopped.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: imem_req=1. On imem_ready, latch IR=imem_rdata and go to DECODE.
- DECODE: read src1, src2 and dst registers into operand latches.
  - Opcode not in the supported set: go to HALT.
- EXEC: compute the result.
  - ADD: src1 + (imm ? imm : src2), modulo 2^DATA_WIDTH.
  - AND: the same operands with bitwise AND.
  - MOV: imm ? imm : src2.
  - LDW/STW: address = src1 + sext(imm16), then go to MEM. All other opcodes go to WB.
- MEM: dmem_req=1, dmem_we=(STW), dmem_wdata=dst register value. Hold all outputs stable until dmem_ready, then go to WB. LDW latches dmem_rdata.
- WB (1 cycle, retire=1, then FETCH):
  - ADD/AND/MOV/LDW: write the result to dst. Set CC exactly one-hot from the result interpreted as signed: N if MSB=1, Z if 0, else P.
  - STW and control flow: CC unchanged.
  - PC update:
    - default PC+4.
    - BR taken when (nzp & CC)!=0: PC+4+(sext(imm16)<<2). nzp=000 is never taken.
    - JMP: PC=src1.
    - JSR: LINK_REG=PC+4, then PC+4+(sext(imm16)<<2).
    - JSRR: LINK_REG=PC+4, then PC=src1. The target is read before the link write, so JSRR with src1=LINK_REG uses the old value.
  - All PC arithmetic wraps modulo 2^PC_WIDTH.
- HALT: halted=1, no requests, stays until reset.
- Latency with zero-wait memory: ALU/branch instructions take 4 cycles; LDW/STW take 5. Each wait cycle adds 1.
- Handshakes: req stays high until ready. Requests never overlap (imem and dmem are never requested in the same cycle).

Test Plan:
- Reset, then MOV R1,#5; MOV R2,#-3; ADD R3,R1,R2 with zero-wait memory -> R3=2, CC=P, 3 retire pulses at cycles 4/8/12, pc_out=12.
- MOV R4,#0x00FF; AND R5,R4,#0 -> R5=0, CC=Z exactly 3'b010.
- STW R1,[R0+#0x10] then LDW R6,[R0+#0x10] with dmem_ready delayed 3 cycles -> dmem_addr=0x10, dmem_wdata=5; R6=5; each access instruction takes 8 cycles.
- CC=N, BRn offset -2 at PC=0x20 -> PC=0x1C. Same branch as BRzp -> PC=0x24.
- JSR +4 at PC=0x40 -> R7=0x44, PC=0x54. JSRR R7 at PC=0x54 -> PC=0x44, R7=0x58.
- lock low for 5 cycles during MEM -> dmem_req=0 and state frozen; resumes and completes. Illegal opcode 5'b11111 -> halted=1, no further imem_req until reset_n=0.
